// File: rtl/fft_radix2_pipe_if.sv
// rtl/fft_radix2_pipe_if.sv - frame stream bus for fft_radix2_pipe; inv mode bit present when FFT_INVERSE_EN is defined
interface fft_radix2_pipe_if #(
    parameter int LOG2N = 3,
    parameter int W     = 16
);
    localparam int N = 1 << LOG2N;

    logic           in_valid;
    logic           in_ready;
    logic [N*W-1:0] in_re;
    logic [N*W-1:0] in_im;
    logic           out_valid;
    logic           out_ready;
    logic [N*W-1:0] out_re;
    logic [N*W-1:0] out_im;
`ifdef FFT_INVERSE_EN
    logic           inv;
`endif

    // Source/sink side: drives input frames and output acceptance
    modport master (
`ifdef FFT_INVERSE_EN
        output inv,
`endif
        output in_valid, in_re, in_im, out_ready,
        input  in_ready, out_valid, out_re, out_im
    );

    // Transform side
    modport slave (
`ifdef FFT_INVERSE_EN
        input  inv,
`endif
        input  in_valid, in_re, in_im, out_ready,
        output in_ready, out_valid, out_re, out_im
    );
endinterface

// File: rtl/fft_radix2_pipe.sv
// rtl/fft_radix2_pipe.sv - parallel pipelined radix-2 DIT FFT, per-stage 1/2 scaling; FFT_INVERSE_EN adds per-frame inverse mode
module fft_radix2_pipe #(
    parameter int LOG2N = 3,
    parameter int W     = 16,
    parameter int TW    = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    fft_radix2_pipe_if.slave   bus
);
    localparam int N    = 1 << LOG2N;
    localparam int HALF = N / 2;
    localparam int PW   = W + TW + 1;

    // cos(k*pi/8) for the 16-point master table
    function automatic real cos16(input int k);
        case (k)
            0:       return 1.0;
            1:       return 0.9238795325112867;
            2:       return 0.7071067811865476;
            3:       return 0.3826834323650898;
            4:       return 0.0;
            5:       return -0.3826834323650898;
            6:       return -0.7071067811865476;
            7:       return -0.9238795325112867;
            default: return -1.0;
        endcase
    endfunction

    // Twiddle constant in Q1.(TW-1); sin(k*pi/8) = cos(|4-k|*pi/8); +1.0 clamps to max positive
    function automatic logic signed [TW-1:0] tw_rom(input int idx16, input bit want_sin, input bit negate);
        real v;
        real scaled;
        int  r;
        v      = want_sin ? cos16((idx16 > 4) ? idx16 - 4 : 4 - idx16) : cos16(idx16);
        v      = negate ? -v : v;
        scaled = v * (2.0 ** (TW - 1));
        r      = $rtoi((scaled >= 0.0) ? scaled + 0.5 : scaled - 0.5);
        if (r > (2 ** (TW - 1)) - 1) r = (2 ** (TW - 1)) - 1;
        return TW'(r);
    endfunction

    function automatic int bitrev(input int k);
        int r;
        r = 0;
        for (int b = 0; b < LOG2N; b++) r = r | (((k >> b) & 1) << (LOG2N - 1 - b));
        return r;
    endfunction

    // Stage 0 is the bit-reversed input bank; stage LOG2N drives the outputs
    logic signed [W-1:0] re_q [0:LOG2N][0:N-1];
    logic signed [W-1:0] im_q [0:LOG2N][0:N-1];
    logic signed [W-1:0] re_d [1:LOG2N][0:N-1];
    logic signed [W-1:0] im_d [1:LOG2N][0:N-1];
    logic [LOG2N:0]      vld_q;
`ifdef FFT_INVERSE_EN
    logic [LOG2N-1:0]    inv_q;
`endif
    logic                advance;

    assign advance      = !vld_q[LOG2N] || bus.out_ready;
    assign bus.in_ready = advance;
    assign bus.out_valid = vld_q[LOG2N];

    for (genvar s = 1; s <= LOG2N; s++) begin : g_stage
        localparam int SPAN  = 1 << s;
        localparam int HSPAN = SPAN / 2;
        for (genvar i = 0; i < HALF; i++) begin : g_bfly
            localparam int J   = i % HSPAN;
            localparam int TOP = (i / HSPAN) * SPAN + J;
            localparam int BOT = TOP + HSPAN;
            localparam int M16 = J * (N / SPAN) * (16 / N);

            logic signed [W:0]   pr;
            logic signed [W:0]   pi;
            logic signed [W+1:0] sr;
            logic signed [W+1:0] si;
            logic signed [W+1:0] dr;
            logic signed [W+1:0] di;

            if (M16 == 0) begin : g_bypass
                assign pr = (W+1)'(re_q[s-1][BOT]);
                assign pi = (W+1)'(im_q[s-1][BOT]);
            end else begin : g_mul
                localparam logic signed [TW-1:0] WR   = tw_rom(M16, 1'b0, 1'b0);
                localparam logic signed [TW-1:0] WI_F = tw_rom(M16, 1'b1, 1'b1);
                localparam logic signed [PW-1:0] RND  = PW'(1) << (TW - 2);
                logic signed [TW-1:0] wi;
                logic signed [PW-1:0] br, bi, wr_x, wi_x, acc_r, acc_i;
`ifdef FFT_INVERSE_EN
                localparam logic signed [TW-1:0] WI_I = tw_rom(M16, 1'b1, 1'b0);
                assign wi = inv_q[s-1] ? WI_I : WI_F;
`else
                assign wi = WI_F;
`endif
                assign br    = PW'(re_q[s-1][BOT]);
                assign bi    = PW'(im_q[s-1][BOT]);
                assign wr_x  = PW'(WR);
                assign wi_x  = PW'(wi);
                assign acc_r = br * wr_x - bi * wi_x + RND;
                assign acc_i = br * wi_x + bi * wr_x + RND;
                assign pr    = (W+1)'(acc_r >>> (TW - 1));
                assign pi    = (W+1)'(acc_i >>> (TW - 1));
            end

            assign sr = (W+2)'(re_q[s-1][TOP]) + (W+2)'(pr);
            assign si = (W+2)'(im_q[s-1][TOP]) + (W+2)'(pi);
            assign dr = (W+2)'(re_q[s-1][TOP]) - (W+2)'(pr);
            assign di = (W+2)'(im_q[s-1][TOP]) - (W+2)'(pi);
            assign re_d[s][TOP] = W'(sr >>> 1);
            assign im_d[s][TOP] = W'(si >>> 1);
            assign re_d[s][BOT] = W'(dr >>> 1);
            assign im_d[s][BOT] = W'(di >>> 1);
        end
    end

    // Whole pipeline shifts together on advance and holds otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
`ifdef FFT_INVERSE_EN
            inv_q <= '0;
`endif
            for (int s = 0; s <= LOG2N; s++) begin
                for (int k = 0; k < N; k++) begin
                    re_q[s][k] <= '0;
                    im_q[s][k] <= '0;
                end
            end
        end else if (advance) begin
            vld_q <= {vld_q[LOG2N-1:0], bus.in_valid};
`ifdef FFT_INVERSE_EN
            if (LOG2N > 1) inv_q <= {inv_q[LOG2N-2:0], bus.inv};
            else           inv_q <= bus.inv;
`endif
            if (bus.in_valid) begin
                for (int k = 0; k < N; k++) begin
                    re_q[0][k] <= bus.in_re[bitrev(k)*W +: W];
                    im_q[0][k] <= bus.in_im[bitrev(k)*W +: W];
                end
            end
            for (int s = 1; s <= LOG2N; s++) begin
                for (int k = 0; k < N; k++) begin
                    re_q[s][k] <= re_d[s][k];
                    im_q[s][k] <= im_d[s][k];
                end
            end
        end
    end

    // Flatten the last stage onto the output buses in natural order
    always_comb begin
        bus.out_re = '0;
        bus.out_im = '0;
        for (int k = 0; k < N; k++) begin
            bus.out_re[k*W +: W] = re_q[LOG2N][k];
            bus.out_im[k*W +: W] = im_q[LOG2N][k];
        end
    end
endmodule

// File: tb/tb_fft_radix2_pipe.sv
// tb/tb_fft_radix2_pipe.sv - scoreboard bench for fft_radix2_pipe (N=8, W=16, TW=16); exercises inv when FFT_INVERSE_EN is defined
module tb_fft_radix2_pipe;
    localparam int LOG2N = 3;
    localparam int N     = 8;
    localparam int W     = 16;
    localparam int TW    = 16;
    localparam int FW    = N * W;
    localparam real PI   = 3.14159265358979;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fft_radix2_pipe_if #(.LOG2N(LOG2N), .W(W)) bus ();

    fft_radix2_pipe #(.LOG2N(LOG2N), .W(W), .TW(TW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    int n_in     = 0;
    int n_out    = 0;

    logic [FW-1:0] exp_re_q [$];
    logic [FW-1:0] exp_im_q [$];
    int            exp_tol_q [$];

    task automatic check(input string tag, input int obs, input int exp, input int tol = 0);
        int d;
        d = obs - exp;
        if (d < 0) d = -d;
        n_checks++;
        if (d > tol) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (tol %0d)", tag, obs, exp, tol);
        end
    endtask

    function automatic int rnd(input real v);
        return $rtoi((v >= 0.0) ? v + 0.5 : v - 0.5);
    endfunction

    // Reference: floating-point DFT (or IDFT) scaled by 1/N, rounded to nearest
    function automatic void dft_model(input logic [FW-1:0] xr, input logic [FW-1:0] xi, input bit inv_b,
                                      output logic [FW-1:0] yr, output logic [FW-1:0] yi);
        real sr, si, a, b, th, c, s;
        for (int k = 0; k < N; k++) begin
            sr = 0.0;
            si = 0.0;
            for (int n = 0; n < N; n++) begin
                a  = $signed(xr[n*W +: W]);
                b  = $signed(xi[n*W +: W]);
                th = 2.0 * PI * n * k / N;
                c  = $cos(th);
                s  = inv_b ? $sin(th) : -$sin(th);
                sr = sr + a * c - b * s;
                si = si + a * s + b * c;
            end
            yr[k*W +: W] = W'(rnd(sr / N));
            yi[k*W +: W] = W'(rnd(si / N));
        end
    endfunction

    function automatic logic [FW-1:0] rand_frame();
        logic [FW-1:0] f;
        for (int n = 0; n < N; n++) f[n*W +: W] = W'(int'($urandom_range(16000)) - 8000);
        return f;
    endfunction

    task automatic send(input logic [FW-1:0] xr, input logic [FW-1:0] xi, input bit inv_b, input int tol);
        logic [FW-1:0] yr, yi;
        int n;
        n = 0;
        dft_model(xr, xi, inv_b, yr, yi);
        bus.in_valid = 1'b1;
        bus.in_re    = xr;
        bus.in_im    = xi;
`ifdef FFT_INVERSE_EN
        bus.inv      = inv_b;
`endif
        @(negedge clk);
        while (!bus.in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            check("in_accept_timeout", n, 0);
        end else begin
            exp_re_q.push_back(yr);
            exp_im_q.push_back(yi);
            exp_tol_q.push_back(tol);
            n_in++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
        bus.in_re    = {$urandom, $urandom, $urandom, $urandom};
        bus.in_im    = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_re_q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("drain_pending", exp_re_q.size(), 0);
    endtask

    task automatic latency_probe(input string tag);
        int n;
        n = 0;
        while (!bus.out_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(tag, n, LOG2N);
    endtask

    // Output monitor: scoreboard compare, hold stability and stall handshake
    logic [FW-1:0] held_re, held_im;
    bit            stalled = 1'b0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (stalled) begin
                check("hold_valid", int'(bus.out_valid), 1);
                check("hold_re", int'(bus.out_re == held_re), 1);
                check("hold_im", int'(bus.out_im == held_im), 1);
            end
            if (bus.out_valid && !bus.out_ready) begin
                check("in_ready_stall", int'(bus.in_ready), 0);
                stalled = 1'b1;
                held_re = bus.out_re;
                held_im = bus.out_im;
            end else begin
                stalled = 1'b0;
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_re_q.size() == 0) begin
                    check("unexpected_frame", 1, 0);
                end else begin
                    logic [FW-1:0] er, ei;
                    int tol;
                    er  = exp_re_q.pop_front();
                    ei  = exp_im_q.pop_front();
                    tol = exp_tol_q.pop_front();
                    for (int k = 0; k < N; k++) begin
                        check($sformatf("out_re[%0d] frame %0d", k, n_out),
                              int'($signed(bus.out_re[k*W +: W])), int'($signed(er[k*W +: W])), tol);
                        check($sformatf("out_im[%0d] frame %0d", k, n_out),
                              int'($signed(bus.out_im[k*W +: W])), int'($signed(ei[k*W +: W])), tol);
                    end
                    n_out++;
                end
            end
        end else begin
            stalled = 1'b0;
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    initial begin
        logic [FW-1:0] xr, xi;
        int discarded;
        discarded     = 0;
        bus.in_valid  = 1'b0;
        bus.in_re     = '0;
        bus.in_im     = '0;
        bus.out_ready = 1'b1;
`ifdef FFT_INVERSE_EN
        bus.inv       = 1'b0;
`endif
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", int'(bus.out_valid), 0);
        check("rst_in_ready", int'(bus.in_ready), 1);
        check("rst_out_re_zero", int'(bus.out_re == '0), 1);
        check("rst_out_im_zero", int'(bus.out_im == '0), 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Impulse: every bin 64/8, with latency measured from acceptance
        xr = '0;
        xi = '0;
        xr[0 +: W] = W'(64);
        send(xr, xi, 1'b0, 0);
        idle();
        latency_probe("latency_impulse");
        drain();

        // DC
        for (int n = 0; n < N; n++) xr[n*W +: W] = W'(800);
        send(xr, xi, 1'b0, 0);
        // Nyquist, back-to-back
        for (int n = 0; n < N; n++) xr[n*W +: W] = (n % 2 == 0) ? W'(800) : W'(-800);
        send(xr, xi, 1'b0, 0);
        // Cosine at bin 1
        for (int n = 0; n < N; n++) xr[n*W +: W] = W'(rnd(1024.0 * $cos(2.0 * PI * n / N)));
        send(xr, xi, 1'b0, 1);
        idle();
        drain();

        // Backpressure: 6 frames streamed while the sink stalls for 4 cycles
        fork
            begin
                for (int i = 0; i < 6; i++) send(rand_frame(), rand_frame(), 1'b0, 3);
                idle();
            end
            begin
                repeat (2) @(posedge clk);
                #1 bus.out_ready = 1'b0;
                repeat (4) @(posedge clk);
                #1 bus.out_ready = 1'b1;
            end
        join
        drain();
        check("count_after_backpressure", n_out, n_in);

        // Reset with 3 frames in flight
        for (int i = 0; i < 3; i++) send(rand_frame(), rand_frame(), 1'b0, 3);
        idle();
        #2 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", int'(bus.out_valid), 0);
        check("midrst_out_re_zero", int'(bus.out_re == '0), 1);
        check("midrst_out_im_zero", int'(bus.out_im == '0), 1);
        discarded = exp_re_q.size();
        check("midrst_inflight", discarded, 3);
        exp_re_q.delete();
        exp_im_q.delete();
        exp_tol_q.delete();
        n_in = n_in - discarded;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("postrst_in_ready", int'(bus.in_ready), 1);
        send(rand_frame(), rand_frame(), 1'b0, 3);
        idle();
        latency_probe("latency_after_reset");
        drain();

        // Random stream with bubbles and random sink stalls
        fork
            begin
                for (int i = 0; i < 20; i++) begin
                    send(rand_frame(), rand_frame(), 1'b0, 3);
                    if ($urandom_range(3) == 0) begin
                        idle();
                        @(posedge clk);
                        #1;
                    end
                end
                idle();
            end
            begin
                repeat (60) begin
                    @(posedge clk);
                    #1 bus.out_ready = ($urandom_range(3) != 0);
                end
                bus.out_ready = 1'b1;
            end
        join
        drain();

`ifdef FFT_INVERSE_EN
        // Interleaved forward/inverse frames, back-to-back
        for (int i = 0; i < 8; i++) send(rand_frame(), rand_frame(), (i % 2) == 1, 3);
        idle();
        drain();
`endif

        check("frames_in_vs_out", n_out, n_in);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
